mem_access_stage: RTL and testbench

//  MEM-stage data-memory access unit plus MEM/WB pipeline register for the 5-stage MIPS pipeline.
//  - Takes the store-data forward select from the MEM forwarding unit and picks the store data.
//  - Issues one byte/half/word access per instruction over a req/ack data-memory port.
//  - Stalls upstream stages until the access completes.
//  - Registers results into the WB stage.

---
 rtl/mem_access_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit and MEM/WB pipeline register.
// One byte/half/word access per instruction over a req/ack port; upstream stalls until ack.
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_Valid,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [1:0]        MEM_Size,
  input  logic              MEM_SignExt,
  input  logic [DATA_W-1:0] MEM_Alu_Res,
  input  logic [DATA_W-1:0] MEM_rt_Data,
  input  logic [1:0]        MEM_Forward,
  input  logic [DATA_W-1:0] WB_Fwd_Data,
  input  logic [DATA_W-1:0] WBIF_Fwd_Data,
  input  logic [4:0]        MEM_WeSel,
  input  logic              MEM_RegWrite,
  input  logic              MEM_Mem2R,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              MEM_Stall,
  output logic              MEM_Misalign,
  output logic              WB_Valid,
  output logic              WB_RegWrite,
  output logic              WB_Mem2R,
  output logic [4:0]        WB_WeSel,
  output logic [DATA_W-1:0] WB_Alu_Res,
  output logic [DATA_W-1:0] WB_Mem_Data
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_next;

  // Access context captured at launch; drives the memory port for the whole access.
  logic [DATA_W-1:0] acc_alu;
  logic              acc_we;
  logic [3:0]        acc_be;
  logic [DATA_W-1:0] acc_wdata;
  logic [1:0]        acc_size;
  logic              acc_signext;
  logic [4:0]        acc_wesel;
  logic              acc_regwrite;
  logic              acc_mem2r;

  logic              mem_op;
  logic              misaligned;
  logic              launch;
  logic              latch_en;
  logic [DATA_W-1:0] store_src;
  logic [3:0]        be_calc;
  logic [DATA_W-1:0] wdata_calc;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  logic              wb_valid_n;
  logic              wb_regwrite_n;
  logic              wb_mem2r_n;
  logic [4:0]        wb_wesel_n;
  logic [DATA_W-1:0] wb_alu_n;
  logic [DATA_W-1:0] wb_mem_n;
  logic              misalign_n;

  assign mem_op = MEM_MemRead | MEM_MemWrite;

  always_comb begin
    case (MEM_Size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = MEM_Alu_Res[0];
      default: misaligned = (MEM_Alu_Res[1:0] != 2'b00);
    endcase
  end

  assign launch = MEM_Valid & mem_op & ~misaligned;

  always_comb begin
    case (MEM_Forward)
      2'b10:   store_src = WB_Fwd_Data;
      2'b01:   store_src = WBIF_Fwd_Data;
      default: store_src = MEM_rt_Data;
    endcase
  end

  always_comb begin
    case (MEM_Size)
      2'b00:   be_calc = 4'b0001 << MEM_Alu_Res[1:0];
      2'b01:   be_calc = MEM_Alu_Res[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase
  end

  always_comb begin
    wdata_calc = '0;
    if (MEM_MemWrite) begin
      case (MEM_Size)
        2'b00:   wdata_calc = {4{store_src[7:0]}};
        2'b01:   wdata_calc = {2{store_src[15:0]}};
        default: wdata_calc = store_src;
      endcase
    end
  end

  // Lane select uses the latched address, not the live MEM input.
  always_comb begin
    case (acc_alu[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = acc_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (acc_size)
      2'b00:   ld_ext = acc_signext ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
      2'b01:   ld_ext = acc_signext ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    dmem_req      = 1'b0;
    MEM_Stall     = 1'b0;
    latch_en      = 1'b0;
    misalign_n    = 1'b0;
    wb_valid_n    = 1'b0;
    wb_regwrite_n = 1'b0;
    wb_mem2r_n    = 1'b0;
    wb_wesel_n    = '0;
    wb_alu_n      = '0;
    wb_mem_n      = '0;
    case (state)
      IDLE: begin
        if (launch) begin
          MEM_Stall  = 1'b1;
          latch_en   = 1'b1;
          state_next = ACCESS;
        end else if (MEM_Valid && mem_op) begin
          misalign_n = 1'b1;
          wb_valid_n = 1'b1;
          wb_wesel_n = MEM_WeSel;
          wb_alu_n   = MEM_Alu_Res;
        end else if (MEM_Valid) begin
          wb_valid_n    = 1'b1;
          wb_regwrite_n = MEM_RegWrite;
          wb_mem2r_n    = MEM_Mem2R;
          wb_wesel_n    = MEM_WeSel;
          wb_alu_n      = MEM_Alu_Res;
        end
      end
      ACCESS: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_next    = IDLE;
          wb_valid_n    = 1'b1;
          wb_regwrite_n = acc_regwrite;
          wb_mem2r_n    = acc_mem2r;
          wb_wesel_n    = acc_wesel;
          wb_alu_n      = acc_alu;
          wb_mem_n      = acc_we ? '0 : ld_ext;
        end else begin
          MEM_Stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_alu      <= '0;
      acc_we       <= 1'b0;
      acc_be       <= '0;
      acc_wdata    <= '0;
      acc_size     <= '0;
      acc_signext  <= 1'b0;
      acc_wesel    <= '0;
      acc_regwrite <= 1'b0;
      acc_mem2r    <= 1'b0;
    end else if (latch_en) begin
      acc_alu      <= MEM_Alu_Res;
      acc_we       <= MEM_MemWrite;
      acc_be       <= be_calc;
      acc_wdata    <= wdata_calc;
      acc_size     <= MEM_Size;
      acc_signext  <= MEM_SignExt;
      acc_wesel    <= MEM_WeSel;
      acc_regwrite <= MEM_RegWrite;
      acc_mem2r    <= MEM_Mem2R;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_Valid     <= 1'b0;
      WB_RegWrite  <= 1'b0;
      WB_Mem2R     <= 1'b0;
      WB_WeSel     <= '0;
      WB_Alu_Res   <= '0;
      WB_Mem_Data  <= '0;
      MEM_Misalign <= 1'b0;
    end else begin
      WB_Valid     <= wb_valid_n;
      WB_RegWrite  <= wb_regwrite_n;
      WB_Mem2R     <= wb_mem2r_n;
      WB_WeSel     <= wb_wesel_n;
      WB_Alu_Res   <= wb_alu_n;
      WB_Mem_Data  <= wb_mem_n;
      MEM_Misalign <= misalign_n;
    end
  end

  assign dmem_we    = acc_we;
  assign dmem_addr  = {acc_alu[ADDR_W-1:2], 2'b00};
  assign dmem_be    = acc_be;
  assign dmem_wdata = acc_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage: reset, stores, loads, misalignment, forwarding.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        MEM_Valid, MEM_MemRead, MEM_MemWrite, MEM_SignExt;
  logic [1:0]  MEM_Size, MEM_Forward;
  logic [31:0] MEM_Alu_Res, MEM_rt_Data, WB_Fwd_Data, WBIF_Fwd_Data;
  logic [4:0]  MEM_WeSel;
  logic        MEM_RegWrite, MEM_Mem2R;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        MEM_Stall, MEM_Misalign;
  logic        WB_Valid, WB_RegWrite, WB_Mem2R;
  logic [4:0]  WB_WeSel;
  logic [31:0] WB_Alu_Res, WB_Mem_Data;

  int unsigned vectors;
  int unsigned miscompares;

  mem_access_stage #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_Valid(MEM_Valid), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Size(MEM_Size), .MEM_SignExt(MEM_SignExt), .MEM_Alu_Res(MEM_Alu_Res),
    .MEM_rt_Data(MEM_rt_Data), .MEM_Forward(MEM_Forward), .WB_Fwd_Data(WB_Fwd_Data),
    .WBIF_Fwd_Data(WBIF_Fwd_Data), .MEM_WeSel(MEM_WeSel), .MEM_RegWrite(MEM_RegWrite),
    .MEM_Mem2R(MEM_Mem2R), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MEM_Stall(MEM_Stall), .MEM_Misalign(MEM_Misalign), .WB_Valid(WB_Valid),
    .WB_RegWrite(WB_RegWrite), .WB_Mem2R(WB_Mem2R), .WB_WeSel(WB_WeSel),
    .WB_Alu_Res(WB_Alu_Res), .WB_Mem_Data(WB_Mem_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    MEM_Valid = 0; MEM_MemRead = 0; MEM_MemWrite = 0; MEM_Size = 2'b00; MEM_SignExt = 0;
    MEM_Alu_Res = '0; MEM_rt_Data = '0; MEM_Forward = 2'b00; WB_Fwd_Data = '0;
    WBIF_Fwd_Data = '0; MEM_WeSel = '0; MEM_RegWrite = 0; MEM_Mem2R = 0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", dmem_req); end
    vectors++; if (MEM_Stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b want 0", MEM_Stall); end
    vectors++; if (MEM_Misalign !== 1'b0) begin miscompares++; $display("FAIL rst_misalign got %b want 0", MEM_Misalign); end
    vectors++; if ({WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel} !== 8'h00) begin miscompares++; $display("FAIL rst_wb_ctrl got %h want 00", {WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel}); end
    vectors++; if ({WB_Alu_Res, WB_Mem_Data} !== 64'h0) begin miscompares++; $display("FAIL rst_wb_data got %h want 0", {WB_Alu_Res, WB_Mem_Data}); end
    vectors++; if ({dmem_be, dmem_addr, dmem_wdata} !== 68'h0) begin miscompares++; $display("FAIL rst_dmem got %h want 0", {dmem_be, dmem_addr, dmem_wdata}); end
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    MEM_Valid = 1; MEM_MemRead = 1; MEM_Size = 2'b10; MEM_Alu_Res = 32'h0000_0100;
    MEM_WeSel = 5'd4; MEM_RegWrite = 1; MEM_Mem2R = 1;
    next_cycle();
    vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL rma_req_before got %b want 1", dmem_req); end
    clear_inputs();
    rst_n = 0;
    #1;
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL rma_req_drop got %b want 0", dmem_req); end
    vectors++; if ({WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel} !== 8'h00) begin miscompares++; $display("FAIL rma_wb got %h want 00", {WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel}); end
    next_cycle();
    rst_n = 1;
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    vectors++; if (MEM_Stall !== 1'b0) begin miscompares++; $display("FAIL rma_stale_stall got %b want 0", MEM_Stall); end
    next_cycle();
    vectors++; if (WB_Valid !== 1'b0) begin miscompares++; $display("FAIL rma_stale_wbvalid got %b want 0", WB_Valid); end
    vectors++; if (WB_Mem_Data !== 32'h0) begin miscompares++; $display("FAIL rma_stale_wbdata got %h want 0", WB_Mem_Data); end
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL rma_stale_req got %b want 0", dmem_req); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_store_byte();
    MEM_Valid = 1; MEM_MemWrite = 1; MEM_Size = 2'b00; MEM_Alu_Res = 32'h0000_1003;
    MEM_rt_Data = 32'h0000_00AB; MEM_Forward = 2'b10; WB_Fwd_Data = 32'h1234_5678;
    #1;
    vectors++; if (MEM_Stall !== 1'b1) begin miscompares++; $display("FAIL sb_stall_launch got %b want 1", MEM_Stall); end
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL sb_req_launch got %b want 0", dmem_req); end
    next_cycle();
    WB_Fwd_Data = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) dmem_ack = 1;
      #1;
      vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL sb_req c%0d got %b want 1", c, dmem_req); end
      vectors++; if (dmem_be !== 4'b1000) begin miscompares++; $display("FAIL sb_be c%0d got %b want 1000", c, dmem_be); end
      vectors++; if (dmem_wdata !== 32'h7878_7878) begin miscompares++; $display("FAIL sb_wdata c%0d got %h want 78787878", c, dmem_wdata); end
      vectors++; if ({dmem_we, dmem_addr} !== {1'b1, 32'h0000_1000}) begin miscompares++; $display("FAIL sb_we_addr c%0d got %h want 100001000", c, {dmem_we, dmem_addr}); end
      vectors++; if (MEM_Stall !== (c != 2)) begin miscompares++; $display("FAIL sb_stall c%0d got %b want %b", c, MEM_Stall, c != 2); end
      next_cycle();
    end
    clear_inputs();
    #1;
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL sb_req_done got %b want 0", dmem_req); end
    vectors++; if ({WB_Valid, WB_RegWrite} !== 2'b10) begin miscompares++; $display("FAIL sb_wb_ctrl got %b want 10", {WB_Valid, WB_RegWrite}); end
    vectors++; if (WB_Alu_Res !== 32'h0000_1003) begin miscompares++; $display("FAIL sb_wb_alu got %h want 00001003", WB_Alu_Res); end
    vectors++; if (WB_Mem_Data !== 32'h0) begin miscompares++; $display("FAIL sb_wb_mem got %h want 0", WB_Mem_Data); end
    next_cycle();
  endtask

  task automatic test_load_half();
    MEM_Valid = 1; MEM_MemRead = 1; MEM_Size = 2'b01; MEM_SignExt = 1;
    MEM_Alu_Res = 32'h0000_2002; MEM_WeSel = 5'd5; MEM_RegWrite = 1; MEM_Mem2R = 1;
    #1;
    vectors++; if (MEM_Stall !== 1'b1) begin miscompares++; $display("FAIL lh_stall_launch got %b want 1", MEM_Stall); end
    next_cycle();
    vectors++; if ({dmem_req, dmem_we, dmem_be} !== 6'b10_1100) begin miscompares++; $display("FAIL lh_port got %b want 101100", {dmem_req, dmem_we, dmem_be}); end
    vectors++; if (dmem_wdata !== 32'h0) begin miscompares++; $display("FAIL lh_wdata got %h want 0", dmem_wdata); end
    dmem_ack = 1; dmem_rdata = 32'h8001_0000;
    #1;
    vectors++; if (MEM_Stall !== 1'b0) begin miscompares++; $display("FAIL lh_stall_ack got %b want 0", MEM_Stall); end
    next_cycle();
    clear_inputs();
    #1;
    vectors++; if (WB_Mem_Data !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_wb_mem got %h want ffff8001", WB_Mem_Data); end
    vectors++; if ({WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel} !== {3'b111, 5'd5}) begin miscompares++; $display("FAIL lh_wb_ctrl got %h want e5", {WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel}); end
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL lh_req_done got %b want 0", dmem_req); end
    next_cycle();
  endtask

  task automatic test_misaligned();
    MEM_Valid = 1; MEM_MemRead = 1; MEM_Size = 2'b10; MEM_Alu_Res = 32'h0000_2001;
    MEM_WeSel = 5'd7; MEM_RegWrite = 1; MEM_Mem2R = 1;
    #1;
    vectors++; if ({MEM_Stall, dmem_req} !== 2'b00) begin miscompares++; $display("FAIL lw_mis_stall_req got %b want 00", {MEM_Stall, dmem_req}); end
    next_cycle();
    clear_inputs();
    #1;
    vectors++; if (MEM_Misalign !== 1'b1) begin miscompares++; $display("FAIL lw_mis_pulse got %b want 1", MEM_Misalign); end
    vectors++; if ({WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel} !== {3'b100, 5'd7}) begin miscompares++; $display("FAIL lw_mis_wb got %h want 87", {WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel}); end
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL lw_mis_req got %b want 0", dmem_req); end
    next_cycle();
    vectors++; if (MEM_Misalign !== 1'b0) begin miscompares++; $display("FAIL lw_mis_pulse_end got %b want 0", MEM_Misalign); end
  endtask

  task automatic test_back_to_back();
    MEM_Valid = 1; MEM_Alu_Res = 32'h0000_0055; MEM_WeSel = 5'd3; MEM_RegWrite = 1;
    #1;
    vectors++; if (MEM_Stall !== 1'b0) begin miscompares++; $display("FAIL b2b_add_stall got %b want 0", MEM_Stall); end
    next_cycle();
    vectors++; if ({WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel} !== {3'b110, 5'd3}) begin miscompares++; $display("FAIL b2b_add_wb got %h want c3", {WB_Valid, WB_RegWrite, WB_Mem2R, WB_WeSel}); end
    vectors++; if ({WB_Alu_Res, WB_Mem_Data} !== {32'h55, 32'h0}) begin miscompares++; $display("FAIL b2b_add_data got %h want 0000005500000000", {WB_Alu_Res, WB_Mem_Data}); end
    MEM_MemWrite = 1; MEM_RegWrite = 0; MEM_WeSel = 5'd0; MEM_Size = 2'b10;
    MEM_Alu_Res = 32'h0000_4000; MEM_rt_Data = 32'h1111_1111; MEM_Forward = 2'b01;
    WBIF_Fwd_Data = 32'hCAFE_F00D; WB_Fwd_Data = 32'h2222_2222;
    #1;
    vectors++; if (MEM_Stall !== 1'b1) begin miscompares++; $display("FAIL b2b_sw_stall got %b want 1", MEM_Stall); end
    next_cycle();
    vectors++; if (dmem_wdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL b2b_sw_wdata got %h want cafef00d", dmem_wdata); end
    vectors++; if ({dmem_req, dmem_we, dmem_be} !== 6'b11_1111) begin miscompares++; $display("FAIL b2b_sw_port got %b want 111111", {dmem_req, dmem_we, dmem_be}); end
    vectors++; if (dmem_addr !== 32'h0000_4000) begin miscompares++; $display("FAIL b2b_sw_addr got %h want 00004000", dmem_addr); end
    vectors++; if (WB_Valid !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble got %b want 0", WB_Valid); end
    dmem_ack = 1;
    next_cycle();
    clear_inputs();
    #1;
    vectors++; if ({WB_Valid, WB_Alu_Res} !== {1'b1, 32'h0000_4000}) begin miscompares++; $display("FAIL b2b_sw_wb got %h want 100004000", {WB_Valid, WB_Alu_Res}); end
    next_cycle();
  endtask

  task automatic test_load_byte_unsigned();
    dmem_ack = 1; dmem_rdata = 32'hA5A5_A5A5;
    next_cycle();
    vectors++; if ({dmem_req, WB_Valid} !== 2'b00) begin miscompares++; $display("FAIL lbu_idle_ack got %b want 00", {dmem_req, WB_Valid}); end
    MEM_Valid = 1; MEM_MemRead = 1; MEM_Size = 2'b00; MEM_SignExt = 0;
    MEM_Alu_Res = 32'h0000_3001; MEM_WeSel = 5'd9; MEM_RegWrite = 1; MEM_Mem2R = 1;
    #1;
    vectors++; if (MEM_Stall !== 1'b1) begin miscompares++; $display("FAIL lbu_stall_launch got %b want 1", MEM_Stall); end
    next_cycle();
    dmem_ack = 0;
    #1;
    vectors++; if ({dmem_req, dmem_be, MEM_Stall} !== 6'b1_0010_1) begin miscompares++; $display("FAIL lbu_port got %b want 100101", {dmem_req, dmem_be, MEM_Stall}); end
    vectors++; if (dmem_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL lbu_addr got %h want 00003000", dmem_addr); end
    next_cycle();
    dmem_ack = 1; dmem_rdata = 32'h0000_F100;
    next_cycle();
    clear_inputs();
    #1;
    vectors++; if (WB_Mem_Data !== 32'h0000_00F1) begin miscompares++; $display("FAIL lbu_wb_mem got %h want 000000f1", WB_Mem_Data); end
    vectors++; if ({WB_Valid, WB_Mem2R, WB_WeSel} !== {2'b11, 5'd9}) begin miscompares++; $display("FAIL lbu_wb_ctrl got %h want 69", {WB_Valid, WB_Mem2R, WB_WeSel}); end
    next_cycle();
  endtask

  task automatic test_load_byte_signed();
    MEM_Valid = 1; MEM_MemRead = 1; MEM_Size = 2'b00; MEM_SignExt = 1;
    MEM_Alu_Res = 32'h0000_3003; MEM_WeSel = 5'd10; MEM_RegWrite = 1; MEM_Mem2R = 1;
    next_cycle();
    vectors++; if (dmem_be !== 4'b1000) begin miscompares++; $display("FAIL lb_be got %b want 1000", dmem_be); end
    dmem_ack = 1; dmem_rdata = 32'h9C00_0000;
    next_cycle();
    clear_inputs();
    #1;
    vectors++; if (WB_Mem_Data !== 32'hFFFF_FF9C) begin miscompares++; $display("FAIL lb_wb_mem got %h want ffffff9c", WB_Mem_Data); end
    next_cycle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_reset_mid_access();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_back_to_back();
    test_load_byte_unsigned();
    test_load_byte_signed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
